// File: rtl/tinker_program_loader_pkg.sv
// Shared definitions for the program loader: memory map defaults, widths and FSM states.
package tinker_program_loader_pkg;

  localparam logic [63:0] LOADER_BASE_ADDR = 64'h2000;
  localparam int unsigned LOADER_MEM_BYTES = 524288;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  // States in which the upstream byte stream is consumed.
  function automatic logic accepts_bytes(loader_state_e s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/tinker_program_loader_if.sv
// Byte stream and instruction-memory write bus seen by the loader.
interface tinker_program_loader_if;
  import tinker_program_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ready;

  modport master (
    input  in_valid, in_data, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/tinker_word_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; pulses word_valid_c on the fourth byte.
module tinker_word_assembler
  import tinker_program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  logic [1:0]         idx_q, idx_d;
  logic [WORD_W-9:0]  shreg_q, shreg_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= 2'd0;
      shreg_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // Newest byte enters at the top so the first byte ends up in bits [7:0].
  always_comb begin
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (clear) begin
      idx_d = 2'd0;
    end else if (byte_en) begin
      idx_d   = idx_q + 2'd1;
      shreg_d = {byte_in, shreg_q[WORD_W-9:BYTE_W]};
    end
  end

  assign word_valid_c = byte_en && !clear && (idx_q == 2'd3);
  assign word_c       = {byte_in, shreg_q};

endmodule

// File: rtl/tinker_program_loader.sv
// Streams a counted, XOR-checksummed program image into instruction memory while holding the core.
module tinker_program_loader
  import tinker_program_loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = LOADER_BASE_ADDR,
  parameter int unsigned MEM_BYTES = LOADER_MEM_BYTES
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  tinker_program_loader_if.master bus,
  output logic                    core_hold,
  output logic                    done,
  output logic                    error
);

  localparam logic [ADDR_W-1:0] MAX_WORDS = (64'(MEM_BYTES) - BASE_ADDR) >> 2;

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] remaining_q, remaining_d;
  logic [WORD_W-1:0] csum_q, csum_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              core_hold_q, core_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              byte_en_c;
  logic              word_valid_c;
  logic [WORD_W-1:0] word_c;

  assign byte_en_c = bus.in_valid && in_ready_q;

  tinker_word_assembler u_asm (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (!in_ready_q),
    .byte_en      (byte_en_c),
    .byte_in      (bus.in_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      remaining_q <= '0;
      csum_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      core_hold_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      remaining_q <= remaining_d;
      csum_q      <= csum_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      core_hold_q <= core_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Next-state: start is only honoured from the idle/terminal states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_HDR;
      ST_HDR: begin
        if (word_valid_c) begin
          if (word_c == '0)                    state_d = ST_CHK;
          else if (64'(word_c) > MAX_WORDS)    state_d = ST_ERR;
          else                                 state_d = ST_DATA;
        end
      end
      ST_DATA:  if (word_valid_c) state_d = ST_WRITE;
      ST_WRITE: if (bus.mem_ready) state_d = (remaining_q == 32'd1) ? ST_CHK : ST_DATA;
      ST_CHK:   if (word_valid_c) state_d = (word_c == csum_q) ? ST_DONE : ST_ERR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath updates plus Moore outputs registered from the next state.
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    remaining_d = remaining_q;
    csum_d      = csum_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          addr_d      = BASE_ADDR;
          remaining_d = '0;
          csum_d      = '0;
        end
      end
      ST_HDR:  if (word_valid_c) remaining_d = word_c;
      ST_DATA: begin
        if (word_valid_c) begin
          wdata_d = word_c;
          csum_d  = csum_q ^ word_c;
        end
      end
      ST_WRITE: begin
        if (bus.mem_ready) begin
          addr_d      = addr_q + 64'd4;
          remaining_d = remaining_q - 32'd1;
        end
      end
      default: ;
    endcase

    in_ready_d  = accepts_bytes(state_d);
    mem_we_d    = (state_d == ST_WRITE);
    core_hold_d = (state_d != ST_DONE);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERR);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign core_hold     = core_hold_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_tinker_program_loader.sv
// Scoreboard bench for the program loader: random and directed images against a word-level model.
module tb_tinker_program_loader;

  localparam logic [63:0] BASE  = 64'h2000;
  localparam logic [63:0] LIMIT = (64'd524288 - 64'h2000) >> 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic start   = 1'b0;
  logic core_hold, done, error;

  tinker_program_loader_if bus();

  tinker_program_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .bus       (bus),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int writes_seen = 0;
  int hold_expect = -1;
  int stall_n = 0;
  int gap_max = 2;
  int wcnt = 0;
  int we_cycles = 0;
  bit held = 1'b0;
  logic [63:0] prev_addr;
  logic [31:0] prev_data;

  logic [63:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] prog[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory side: mem_ready rises after stall_n wait cycles of each write request.
  initial begin
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_we === 1'b1) begin
        bus.mem_ready = (wcnt >= stall_n);
        wcnt++;
      end else begin
        bus.mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: checks each accepted write against the expected queue and bus stability.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) begin
        we_cycles++;
        check("in_ready_during_write", 64'(bus.in_ready), 64'd0);
        if (held) begin
          check("addr_stable", bus.mem_addr, prev_addr);
          check("data_stable", 64'(bus.mem_wdata), 64'(prev_data));
        end
        if (bus.mem_ready === 1'b1) begin
          writes_seen++;
          if (exp_addr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", bus.mem_addr, bus.mem_wdata);
          end else begin
            check("write_addr", bus.mem_addr, exp_addr_q.pop_front());
            check("write_data", 64'(bus.mem_wdata), 64'(exp_data_q.pop_front()));
          end
          if (hold_expect >= 0) check("we_hold_cycles", 64'(we_cycles), 64'(hold_expect));
          we_cycles = 0;
          held = 1'b0;
        end else begin
          held = 1'b1;
          prev_addr = bus.mem_addr;
          prev_data = bus.mem_wdata;
        end
      end else begin
        held = 1'b0;
        we_cycles = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1 for byte 0x%0h", b);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Model: words land at BASE+4*i in order; error on oversize count or XOR mismatch.
  task automatic run_program(input logic [31:0] n, input logic [31:0] csum, input bit inject);
    logic [31:0] x;
    bit exp_err;
    bit ovf;
    int w0;
    int t;
    pulse_start();
    @(negedge clk);
    check("start_clears_done", 64'(done), 64'd0);
    check("start_clears_error", 64'(error), 64'd0);
    check("hold_while_loading", 64'(core_hold), 64'd1);
    check("ready_in_hdr", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    w0 = writes_seen;
    x = '0;
    ovf = (64'(n) > LIMIT);
    send_word(n);
    if (ovf) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        exp_addr_q.push_back(BASE + 64'(4 * i));
        exp_data_q.push_back(prog[i]);
        x ^= prog[i];
        if (inject && i == 0) begin
          send_byte(prog[i][7:0]);
          send_byte(prog[i][15:8]);
          pulse_start();
          send_byte(prog[i][23:16]);
          send_byte(prog[i][31:24]);
        end else begin
          send_word(prog[i]);
        end
      end
      send_word(csum);
      exp_err = (csum != x);
    end
    t = 0;
    while (!(done || error) && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("done", 64'(done), 64'(!exp_err));
    check("error", 64'(error), 64'(exp_err));
    check("core_hold", 64'(core_hold), 64'(exp_err));
    check("write_count", 64'(writes_seen - w0), ovf ? 64'd0 : 64'(n));
    check("pending_writes", 64'(exp_addr_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] n;
    logic [31:0] cs;
    int w0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_mem_addr", bus.mem_addr, BASE);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_core_hold", 64'(core_hold), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_ready", 64'(bus.in_ready), 64'd0);
      check("idle_hold", 64'(core_hold), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;

    // Reference two-word image, no stall then a 3-cycle stall per write.
    prog = '{32'h12345678, 32'h00000001};
    stall_n = 0; hold_expect = 1;
    run_program(32'd2, 32'h12345679, 1'b0);
    stall_n = 3; hold_expect = 4;
    run_program(32'd2, 32'h12345679, 1'b0);

    // Bad checksum, then recovery with a start pulse injected mid-word.
    stall_n = 0; hold_expect = 1;
    prog = '{32'hDEADBEEF};
    run_program(32'd1, 32'hDEADBEEE, 1'b0);
    prog = '{32'h12345678, 32'h00000001};
    run_program(32'd2, 32'h12345679, 1'b1);

    // Size boundaries.
    prog.delete();
    run_program(32'd129025, 32'd0, 1'b0);
    run_program(32'd0, 32'd0, 1'b0);
    pulse_start();
    send_word(32'd129024);
    repeat (3) @(negedge clk);
    check("max_count_no_error", 64'(error), 64'd0);
    check("max_count_ready", 64'(bus.in_ready), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_data_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset while the second word's write is stalled.
    gap_max = 0;
    w0 = writes_seen;
    pulse_start();
    send_word(32'd2);
    exp_addr_q.push_back(BASE);
    exp_data_q.push_back(32'hA5A5_0001);
    send_word(32'hA5A5_0001);
    stall_n = 1000; hold_expect = -1;
    send_word(32'hA5A5_0002);
    @(negedge clk);
    check("second_write_pending", 64'(bus.mem_we), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_drops_we", 64'(bus.mem_we), 64'd0);
    check("rst_holds_core", 64'(core_hold), 64'd1);
    check("rst_addr", bus.mem_addr, BASE);
    @(negedge clk);
    reset_n = 1'b1;
    stall_n = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_ignored", 64'(bus.in_ready), 64'd0);
      check("post_rst_no_we", 64'(bus.mem_we), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("lost_write_count", 64'(writes_seen - w0), 64'd1);
    gap_max = 2;

    // Random images with random stalls, gaps, corrupt checksums and oversize headers.
    repeat (12) begin
      n = 32'($urandom_range(0, 6));
      prog.delete();
      cs = '0;
      for (int i = 0; i < int'(n); i++) begin
        prog.push_back($urandom);
        cs ^= prog[i];
      end
      if ($urandom_range(0, 3) == 0) cs ^= (32'd1 << $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) n = 32'(LIMIT) + 32'd1 + 32'($urandom_range(0, 1000));
      stall_n = $urandom_range(0, 3);
      hold_expect = stall_n + 1;
      run_program(n, cs, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
